uart_rx_core: RTL

UART_RX_CORE -- requirements
Module: uart_rx_core

---
 rtl/uart_rx_core.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/uart_rx_core.sv
// uart_rx_core: oversampling UART receiver with a valid/ready word output.
// Ports: CLK, RSTn (sync, active-low), RX_Pin_In (async line), RX_En_Sig,
//   RX_Data/RX_Valid/RX_Ready (word handshake), RX_Busy, RX_Err_Frame,
//   RX_Err_Parity, RX_Overrun (one-cycle pulses).
// Define UART_RX_FIFO_EN for a 4-entry output FIFO; default is one register.
module uart_rx_core #(
   parameter int CLK_DIV     = 434,
   parameter int DATA_BITS   = 8,
   parameter int PARITY_MODE = 0
) (
   input  logic                 CLK,
   input  logic                 RSTn,
   input  logic                 RX_Pin_In,
   input  logic                 RX_En_Sig,
   output logic [DATA_BITS-1:0] RX_Data,
   output logic                 RX_Valid,
   input  logic                 RX_Ready,
   output logic                 RX_Busy,
   output logic                 RX_Err_Frame,
   output logic                 RX_Err_Parity,
   output logic                 RX_Overrun
);

   localparam int BW = $clog2(DATA_BITS + 1);
   localparam logic [15:0] BIT_END = 16'(CLK_DIV - 1);
   localparam logic [15:0] HALF = 16'(CLK_DIV / 2);
   localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);
   localparam logic ODD = (PARITY_MODE == 1);

   typedef enum logic [2:0] {
      IDLE, START, DATA, PARITY, STOP, BREAK
   } state_t;

   state_t               state;
   logic                 sync1;
   logic                 sync2;
   logic                 line_q;
   logic [15:0]          cnt;
   logic [BW-1:0]        bit_cnt;
   logic [DATA_BITS-1:0] shreg;
   logic                 par_ok;
   logic                 fall;
   logic                 centre;
   logic                 good;
   logic                 pop;

   // line_q delays the synchronized line so a 1->0 step is seen once
   assign fall    = line_q & ~sync2;
   assign centre  = (cnt == BIT_END);
   assign good    = (state == STOP) && centre && sync2 && par_ok;
   assign pop     = RX_Valid & RX_Ready;
   assign RX_Busy = (state != IDLE);

   always_ff @(posedge CLK) begin
      if (!RSTn) begin
         sync1         <= 1'b1;
         sync2         <= 1'b1;
         line_q        <= 1'b1;
         state         <= IDLE;
         cnt           <= '0;
         bit_cnt       <= '0;
         shreg         <= '0;
         par_ok        <= 1'b1;
         RX_Err_Frame  <= 1'b0;
         RX_Err_Parity <= 1'b0;
      end else begin
         sync1         <= RX_Pin_In;
         sync2         <= sync1;
         line_q        <= sync2;
         RX_Err_Frame  <= 1'b0;
         RX_Err_Parity <= 1'b0;
         unique case (state)
            IDLE: begin
               if (fall && RX_En_Sig) begin
                  state <= START;
                  cnt   <= '0;
               end
            end
            START: begin
               if (cnt == HALF) begin
                  cnt     <= '0;
                  bit_cnt <= '0;
                  par_ok  <= 1'b1;
                  state   <= sync2 ? IDLE : DATA;
               end else begin
                  cnt <= cnt + 16'd1;
               end
            end
            DATA: begin
               if (centre) begin
                  cnt     <= '0;
                  shreg   <= {sync2, shreg[DATA_BITS-1:1]};
                  bit_cnt <= bit_cnt + 1'b1;
                  if (bit_cnt == LAST_BIT)
                     state <= (PARITY_MODE != 0) ? PARITY : STOP;
               end else begin
                  cnt <= cnt + 16'd1;
               end
            end
            PARITY: begin
               if (centre) begin
                  cnt    <= '0;
                  par_ok <= (sync2 == ((^shreg) ^ ODD));
                  state  <= STOP;
               end else begin
                  cnt <= cnt + 16'd1;
               end
            end
            STOP: begin
               if (centre) begin
                  cnt <= '0;
                  if (!sync2) begin
                     RX_Err_Frame <= 1'b1;
                     state        <= BREAK;
                  end else begin
                     RX_Err_Parity <= ~par_ok;
                     state         <= IDLE;
                  end
               end else begin
                  cnt <= cnt + 16'd1;
               end
            end
            BREAK: begin
               // wait out a held-low line before looking for a new start
               if (sync2)
                  state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef UART_RX_FIFO_EN
   logic [DATA_BITS-1:0] mem [4];
   logic [1:0]           wr_ptr;
   logic [1:0]           rd_ptr;
   logic [2:0]           count;
   logic                 full;
   logic                 push;

   assign full     = count[2];
   // a pop frees the head slot in the same cycle, so a full FIFO can accept
   assign push     = good & (~full | pop);
   assign RX_Valid = (count != 3'd0);
   assign RX_Data  = mem[rd_ptr];

   always_ff @(posedge CLK) begin
      if (!RSTn) begin
         for (int i = 0; i < 4; i++)
            mem[i] <= '0;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count      <= '0;
         RX_Overrun <= 1'b0;
      end else begin
         RX_Overrun <= good & full & ~pop;
         if (push) begin
            mem[wr_ptr] <= shreg;
            wr_ptr      <= wr_ptr + 2'd1;
         end
         if (pop)
            rd_ptr <= rd_ptr + 2'd1;
         count <= count + 3'(push) - 3'(pop);
      end
   end
`else
   logic [DATA_BITS-1:0] hold;
   logic                 full;

   assign RX_Valid = full;
   assign RX_Data  = hold;

   always_ff @(posedge CLK) begin
      if (!RSTn) begin
         hold       <= '0;
         full       <= 1'b0;
         RX_Overrun <= 1'b0;
      end else begin
         RX_Overrun <= good & full & ~pop;
         if (good && (!full || pop)) begin
            hold <= shreg;
            full <= 1'b1;
         end else if (pop) begin
            full <= 1'b0;
         end
      end
   end
`endif

endmodule
